// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - N-digit seven-segment controller with static, blink, scroll and off modes
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits in STATIC/BLINK)
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000,
    parameter int MSG_DEPTH  = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [1:0]              wr_mode,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    msg_push,
    input  logic [3:0]              msg_nibble,
    input  logic                    msg_clear,
    output logic                    msg_full,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int PTR_W    = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int LEN_W    = $clog2(MSG_DEPTH + 1);
    localparam int IDX_W    = LEN_W + 1;
    localparam int BLINK_W  = $clog2(BLINK_DIV);
    localparam int SCROLL_W = $clog2(SCROLL_DIV);

    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
    localparam logic [LEN_W-1:0]    LEN_FULL    = LEN_W'(MSG_DEPTH);
    localparam logic [LEN_W-1:0]    LEN_DIGITS  = LEN_W'(NUM_DIGITS);
    localparam logic [6:0]          SEG_BLANK   = 7'h7F;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    mode_t                   mode_q, mode_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [PTR_W-1:0]        pos_q, pos_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [SCROLL_W-1:0]     scroll_cnt_q, scroll_cnt_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    msg_full_q, msg_full_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [3:0]              msg_mem [MSG_DEPTH];

    logic wr_accept;
    logic push_ok;
    logic [LEN_W-1:0] pos_next_ext;

    assign wr_accept    = wr_valid && wr_ready_q;
    // clear wins over push; a push into a full buffer is dropped
    assign push_ok      = msg_push && !msg_clear && (len_q != LEN_FULL);
    assign pos_next_ext = LEN_W'(pos_q) + LEN_W'(1);

    assign wr_ready = wr_ready_q;
    assign msg_full = msg_full_q;
    assign hex_out  = hex_q;

    // active-low {g..a} encoding of one hex nibble
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // mode/data latch, blink and scroll timing, message length bookkeeping
    always_comb begin
        mode_d       = mode_q;
        data_d       = data_q;
        len_d        = len_q;
        pos_d        = pos_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        scroll_cnt_d = scroll_cnt_q;
        wr_ready_d   = !wr_accept;

        if (wr_accept) begin
            mode_d       = mode_t'(wr_mode);
            data_d       = wr_data;
            blink_cnt_d  = '0;
            phase_d      = 1'b0;
            scroll_cnt_d = '0;
            pos_d        = '0;
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = !phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
                MODE_SCROLL: begin
                    if (scroll_cnt_q == SCROLL_LAST) begin
                        scroll_cnt_d = '0;
                        // only a message longer than the display moves
                        if (len_q > LEN_DIGITS) begin
                            if (pos_next_ext >= len_q) begin
                                pos_d = '0;
                            end else begin
                                pos_d = pos_q + PTR_W'(1);
                            end
                        end
                    end else begin
                        scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
                    end
                end
                MODE_OFF: begin
                    blink_cnt_d  = '0;
                    phase_d      = 1'b0;
                    scroll_cnt_d = '0;
                end
                default: begin
                end
            endcase
        end

        if (msg_clear) begin
            len_d = '0;
            pos_d = '0;
        end else if (push_ok) begin
            len_d = len_q + LEN_W'(1);
        end

        msg_full_d = (len_d == LEN_FULL);
    end

    // per-digit segment selection for the output register, mask applied last
    always_comb begin
        logic [3:0]       nib;
        logic [6:0]       seg;
        logic [IDX_W-1:0] off;
        logic [IDX_W-1:0] idx;
`ifdef LEADING_ZERO_BLANK_EN
        logic             above_zero;
        above_zero = 1'b1;
`endif
        hex_d = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = data_q[4*k +: 4];
            off = IDX_W'(NUM_DIGITS - 1 - k);
            idx = '0;
            seg = SEG_BLANK;
            case (mode_q)
                MODE_STATIC, MODE_BLINK: begin
                    seg = seg7(nib);
                    if (mode_q == MODE_BLINK && phase_q) begin
                        seg = SEG_BLANK;
                    end
`ifdef LEADING_ZERO_BLANK_EN
                    if (above_zero && (nib == 4'h0) && (k != 0)) begin
                        seg = SEG_BLANK;
                    end
`endif
                end
                MODE_SCROLL: begin
                    if (len_q == '0) begin
                        seg = SEG_BLANK;
                    end else if (len_q <= LEN_DIGITS) begin
                        // short message sits left-aligned and does not move
                        if (off < IDX_W'(len_q)) begin
                            seg = seg7(msg_mem[off[PTR_W-1:0]]);
                        end
                    end else begin
                        // pos < len and off < len, so one subtraction is a full wrap
                        idx = IDX_W'(pos_q) + off;
                        if (idx >= IDX_W'(len_q)) begin
                            idx = idx - IDX_W'(len_q);
                        end
                        seg = seg7(msg_mem[idx[PTR_W-1:0]]);
                    end
                end
                default: begin
                    seg = SEG_BLANK;
                end
            endcase
`ifdef LEADING_ZERO_BLANK_EN
            above_zero = above_zero && (nib == 4'h0);
`endif
            if (blank_mask[k]) begin
                seg = SEG_BLANK;
            end
            hex_d[7*k +: 7] = seg;
        end
    end

    // state register with synchronous reset to OFF / empty buffer / blank display
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mode_q       <= MODE_OFF;
            data_q       <= '0;
            len_q        <= '0;
            pos_q        <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            scroll_cnt_q <= '0;
            wr_ready_q   <= 1'b1;
            msg_full_q   <= 1'b0;
            hex_q        <= '1;
        end else begin
            mode_q       <= mode_d;
            data_q       <= data_d;
            len_q        <= len_d;
            pos_q        <= pos_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            scroll_cnt_q <= scroll_cnt_d;
            wr_ready_q   <= wr_ready_d;
            msg_full_q   <= msg_full_d;
            hex_q        <= hex_d;
        end
    end

    // message storage; contents need no reset since len gates every read
    always_ff @(posedge clk_clk) begin
        if (!reset_reset && push_ok) begin
            msg_mem[len_q[PTR_W-1:0]] <= msg_nibble;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_mode;
    logic [23:0] wr_data;
    logic [5:0]  blank_mask;
    logic        msg_push;
    logic [3:0]  msg_nibble;
    logic        msg_clear;
    logic        msg_full;
    logic [41:0] hex_out;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] M_STATIC = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_SCROLL = 2'd2;
    localparam logic [1:0] M_OFF    = 2'd3;
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic [6:0] seg_tab [16];

    hex_display_ctrl #(
        .NUM_DIGITS(6),
        .BLINK_DIV (4),
        .SCROLL_DIV(3),
        .MSG_DEPTH (8)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(reset_reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .blank_mask (blank_mask),
        .msg_push   (msg_push),
        .msg_nibble (msg_nibble),
        .msg_clear  (msg_clear),
        .msg_full   (msg_full),
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] m, input logic [23:0] d);
        wr_valid = 1'b1;
        wr_mode  = m;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        tick();
        tick();
        reset_reset = 1'b0;
        total++;
        if (hex_out !== ALL_BLANK) begin
            bad++;
            $display("FAIL reset_hex got=%h exp=%h", hex_out, ALL_BLANK);
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", wr_ready);
        end
        total++;
        if (msg_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_full got=%b exp=0", msg_full);
        end
    endtask

    task automatic test_static();
        logic [41:0] exp;
`ifdef LEADING_ZERO_BLANK_EN
        exp = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
`else
        exp = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
`endif
        do_write(M_STATIC, 24'h012345);
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL static_ready_low got=%b exp=0", wr_ready);
        end
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL static_ready_back got=%b exp=1", wr_ready);
        end
        total++;
        if (hex_out[6:0] !== 7'h12) begin
            bad++;
            $display("FAIL static_digit0 got=%h exp=12", hex_out[6:0]);
        end
        total++;
        if (hex_out !== exp) begin
            bad++;
            $display("FAIL static_hex got=%h exp=%h", hex_out, exp);
        end
    endtask

    task automatic test_hold_ignored();
        wr_valid = 1'b1;
        wr_mode  = M_STATIC;
        wr_data  = 24'h111111;
        tick();
        wr_data  = 24'h222222;
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_ready got=%b exp=1", wr_ready);
        end
        total++;
        if (hex_out !== {6{7'h79}}) begin
            bad++;
            $display("FAIL hold_first got=%h exp=%h", hex_out, {6{7'h79}});
        end
        wr_valid = 1'b0;
        tick();
        total++;
        if (hex_out !== {6{7'h79}}) begin
            bad++;
            $display("FAIL hold_ignored got=%h exp=%h", hex_out, {6{7'h79}});
        end
    endtask

    task automatic test_blank_mask();
        blank_mask = 6'b100001;
        tick();
        total++;
        if (hex_out !== {7'h7F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h7F}) begin
            bad++;
            $display("FAIL mask_on got=%h exp=%h", hex_out, {7'h7F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h7F});
        end
        blank_mask = 6'b000000;
        tick();
        total++;
        if (hex_out !== {6{7'h79}}) begin
            bad++;
            $display("FAIL mask_off got=%h exp=%h", hex_out, {6{7'h79}});
        end
    endtask

    task automatic test_blink();
        logic [41:0] on_pat;
        logic [41:0] exp;
        on_pat = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        do_write(M_BLINK, 24'hABCDEF);
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i <= 4) ? on_pat : ALL_BLANK;
            total++;
            if (hex_out !== exp) begin
                bad++;
                $display("FAIL blink_cycle%0d got=%h exp=%h", i, hex_out, exp);
            end
        end
        do_write(M_BLINK, 24'hABCDEF);
        total++;
        if (hex_out !== ALL_BLANK) begin
            bad++;
            $display("FAIL blink_rewrite_edge got=%h exp=%h", hex_out, ALL_BLANK);
        end
        for (int j = 1; j <= 5; j++) begin
            tick();
            exp = (j <= 4) ? on_pat : ALL_BLANK;
            total++;
            if (hex_out !== exp) begin
                bad++;
                $display("FAIL blink_restart%0d got=%h exp=%h", j, hex_out, exp);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [41:0] exp;
`ifdef LEADING_ZERO_BLANK_EN
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40};
`else
        exp = {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40};
`endif
        do_write(M_STATIC, 24'h000120);
        tick();
        total++;
        if (hex_out !== exp) begin
            bad++;
            $display("FAIL lz_120 got=%h exp=%h", hex_out, exp);
        end
`ifdef LEADING_ZERO_BLANK_EN
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        exp = {6{7'h40}};
`endif
        do_write(M_STATIC, 24'h000000);
        tick();
        total++;
        if (hex_out !== exp) begin
            bad++;
            $display("FAIL lz_zero got=%h exp=%h", hex_out, exp);
        end
    endtask

    task automatic test_off();
        do_write(M_OFF, 24'h123456);
        tick();
        total++;
        if (hex_out !== ALL_BLANK) begin
            bad++;
            $display("FAIL off_hex got=%h exp=%h", hex_out, ALL_BLANK);
        end
    endtask

    task automatic push_one_to_eight();
        msg_clear = 1'b1;
        tick();
        msg_clear = 1'b0;
        msg_push  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            msg_nibble = 4'(i);
            tick();
        end
        msg_push = 1'b0;
    endtask

    task automatic test_scroll_full();
        logic [41:0] exp;
        int p;
        msg_clear = 1'b1;
        tick();
        msg_clear = 1'b0;
        msg_push  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            msg_nibble = 4'(i);
            tick();
            if (i == 7) begin
                total++;
                if (msg_full !== 1'b0) begin
                    bad++;
                    $display("FAIL full_at7 got=%b exp=0", msg_full);
                end
            end
        end
        total++;
        if (msg_full !== 1'b1) begin
            bad++;
            $display("FAIL full_at8 got=%b exp=1", msg_full);
        end
        msg_nibble = 4'h9;
        tick();
        msg_push = 1'b0;
        total++;
        if (msg_full !== 1'b1) begin
            bad++;
            $display("FAIL full_after9 got=%b exp=1", msg_full);
        end
        do_write(M_SCROLL, 24'h000000);
        for (int c = 1; c <= 25; c++) begin
            tick();
            p = ((c - 1) / 3) % 8;
            for (int k = 0; k < 6; k++) begin
                exp[7*k +: 7] = seg_tab[((p + 5 - k) % 8) + 1];
            end
            total++;
            if (hex_out !== exp) begin
                bad++;
                $display("FAIL scroll_step%0d got=%h exp=%h", c, hex_out, exp);
            end
        end
    endtask

    task automatic test_scroll_short();
        logic [41:0] exp;
        exp = {7'h08, 7'h03, 7'h46, 7'h7F, 7'h7F, 7'h7F};
        msg_clear = 1'b1;
        tick();
        msg_clear = 1'b0;
        msg_push  = 1'b1;
        msg_nibble = 4'hA;
        tick();
        msg_nibble = 4'hB;
        tick();
        msg_nibble = 4'hC;
        tick();
        msg_push = 1'b0;
        do_write(M_SCROLL, 24'h000000);
        for (int c = 1; c <= 6; c++) begin
            tick();
            total++;
            if (hex_out !== exp) begin
                bad++;
                $display("FAIL scroll_short%0d got=%h exp=%h", c, hex_out, exp);
            end
        end
    endtask

    task automatic test_clear_push();
        msg_clear  = 1'b1;
        msg_push   = 1'b1;
        msg_nibble = 4'h5;
        tick();
        msg_clear = 1'b0;
        msg_push  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if (hex_out !== ALL_BLANK) begin
                bad++;
                $display("FAIL clear_push%0d got=%h exp=%h", c, hex_out, ALL_BLANK);
            end
        end
        total++;
        if (msg_full !== 1'b0) begin
            bad++;
            $display("FAIL clear_push_full got=%b exp=0", msg_full);
        end
    endtask

    task automatic test_reset_mid_scroll();
        push_one_to_eight();
        do_write(M_SCROLL, 24'h000000);
        for (int c = 0; c < 5; c++) tick();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        total++;
        if (hex_out !== ALL_BLANK) begin
            bad++;
            $display("FAIL rst_mid_hex got=%h exp=%h", hex_out, ALL_BLANK);
        end
        total++;
        if (msg_full !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_full got=%b exp=0", msg_full);
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready got=%b exp=1", wr_ready);
        end
        tick();
        tick();
        total++;
        if (hex_out !== ALL_BLANK) begin
            bad++;
            $display("FAIL rst_mid_after got=%h exp=%h", hex_out, ALL_BLANK);
        end
    endtask

    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        reset_reset = 1'b1;
        wr_valid    = 1'b0;
        wr_mode     = 2'd0;
        wr_data     = 24'h0;
        blank_mask  = 6'b0;
        msg_push    = 1'b0;
        msg_nibble  = 4'h0;
        msg_clear   = 1'b0;

        test_reset();
        test_static();
        test_hold_ignored();
        test_blank_mask();
        test_blink();
        test_leading_zero();
        test_off();
        test_scroll_full();
        test_scroll_short();
        test_clear_push();
        test_reset_mid_scroll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
